// File: rtl/i2cc_arb_pkg.sv
// Shared definitions for the two-requester I2C controller arbiter:
// state encoding, requester ids and the default lock timeout.
package i2cc_arb_pkg;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_ISSUE = 3'd1;
   localparam logic [2:0] ST_WAIT  = 3'd2;
   localparam logic [2:0] ST_ACK   = 3'd3;
   localparam logic [2:0] ST_HOLD  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE  = ST_IDLE,
      S_ISSUE = ST_ISSUE,
      S_WAIT  = ST_WAIT,
      S_ACK   = ST_ACK,
      S_HOLD  = ST_HOLD
   } state_t;

   localparam logic REQ0 = 1'b0;
   localparam logic REQ1 = 1'b1;

   // 10 ms at 100 MHz
   localparam int DEFAULT_TIMEOUT = 1000000;
   localparam int DEFAULT_TWIDTH  = 20;

endpackage

// File: rtl/i2cc_lock_timer.sv
// Idle-cycle counter for a held lock: cleared on entry to HOLD, counts enabled
// cycles and flags expiry on the TIMEOUT-th one.
module i2cc_lock_timer
   import i2cc_arb_pkg::*;
#(
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int TWIDTH  = DEFAULT_TWIDTH
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expire
);

   localparam logic [TWIDTH-1:0] LAST_COUNT = TWIDTH'(TIMEOUT - 1);

   logic [TWIDTH-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_rst || i_clear) begin
         r_count <= '0;
      end else if (i_enable) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_expire = i_enable && (r_count == LAST_COUNT);

endmodule

// File: rtl/i2cc_arbiter.sv
// Transaction-level round-robin arbiter sharing one I2C controller byte port
// between two requesters. Define I2CC_ARB_LOCK_TIMEOUT_EN to add the HOLD lock timeout.
module i2cc_arbiter
   import i2cc_arb_pkg::*;
#(
   parameter int DWIDTH  = 8,
   parameter int TIMEOUT = DEFAULT_TIMEOUT,
   parameter int TWIDTH  = DEFAULT_TWIDTH
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_r0_start,
   input  logic              i_r0_rdwr,
   input  logic              i_r0_last,
   input  logic [DWIDTH-1:0] i_r0_addr,
   input  logic [DWIDTH-1:0] i_r0_txd,
   output logic [DWIDTH-1:0] o_r0_rxd,
   output logic              o_r0_done,
   output logic              o_r0_grant,
   input  logic              i_r1_start,
   input  logic              i_r1_rdwr,
   input  logic              i_r1_last,
   input  logic [DWIDTH-1:0] i_r1_addr,
   input  logic [DWIDTH-1:0] i_r1_txd,
   output logic [DWIDTH-1:0] o_r1_rxd,
   output logic              o_r1_done,
   output logic              o_r1_grant,
   output logic              o_i2cc_start,
   output logic              o_i2cc_rdwr,
   output logic              o_i2cc_last,
   output logic [DWIDTH-1:0] o_i2cc_addr,
   output logic [DWIDTH-1:0] o_i2cc_txd,
   input  logic [DWIDTH-1:0] i_i2cc_rxd,
   input  logic              i_i2cc_done,
   output logic              o_busy,
   output logic              o_lock_err
);

   if (TIMEOUT < 1 || longint'(TIMEOUT) >= (longint'(1) << TWIDTH)) begin : g_cfg_err
      $error("i2cc_arbiter: TIMEOUT must be in 1 .. 2**TWIDTH-1");
   end

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_owner;
   logic              r_rr;
   logic [1:0]        r_grant;
   logic [1:0]        r_done;
   logic [DWIDTH-1:0] r_rxd0;
   logic [DWIDTH-1:0] r_rxd1;
   logic              r_start;
   logic              r_rdwr;
   logic              r_last;
   logic [DWIDTH-1:0] r_addr;
   logic [DWIDTH-1:0] r_txd;

   logic              w_sel;
   logic              w_sel_owner;
   logic              w_capture;
   logic              w_release;
   logic              w_hold_clear;
   logic              w_hold_idle;
   logic              w_expire;
   logic              w_owner_start;
   logic              w_req_rdwr;
   logic              w_req_last;
   logic [DWIDTH-1:0] w_req_addr;
   logic [DWIDTH-1:0] w_req_txd;

   assign w_owner_start = (r_owner == REQ1) ? i_r1_start : i_r0_start;

   // NOTE: every always_comb output gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_state_nxt  = r_state;
      w_sel        = 1'b0;
      w_sel_owner  = r_owner;
      w_capture    = 1'b0;
      w_release    = 1'b0;
      w_hold_clear = 1'b0;
      w_hold_idle  = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (i_r0_start || i_r1_start) begin
               w_sel       = 1'b1;
               w_sel_owner = (i_r0_start && i_r1_start) ? r_rr : (i_r1_start ? REQ1 : REQ0);
               w_state_nxt = S_ISSUE;
            end
         end
         S_ISSUE: w_state_nxt = S_WAIT;
         S_WAIT: begin
            if (i_i2cc_done) begin
               w_capture   = 1'b1;
               w_state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            if (r_last) begin
               w_release   = 1'b1;
               w_state_nxt = S_IDLE;
            end else begin
               w_hold_clear = 1'b1;
               w_state_nxt  = S_HOLD;
            end
         end
         S_HOLD: begin
            if (w_owner_start) begin
               w_sel       = 1'b1;
               w_state_nxt = S_ISSUE;
            end else begin
               w_hold_idle = 1'b1;
               if (w_expire) begin
                  w_release   = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   assign w_req_rdwr = w_sel_owner ? i_r1_rdwr : i_r0_rdwr;
   assign w_req_last = w_sel_owner ? i_r1_last : i_r0_last;
   assign w_req_addr = w_sel_owner ? i_r1_addr : i_r0_addr;
   assign w_req_txd  = w_sel_owner ? i_r1_txd  : i_r0_txd;

   // Fields are sampled only on a selection; the controller sees them frozen for the whole byte.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_owner <= REQ0;
         r_rr    <= REQ0;
         r_grant <= '0;
         r_done  <= '0;
         r_rxd0  <= '0;
         r_rxd1  <= '0;
         r_start <= 1'b0;
         r_rdwr  <= 1'b0;
         r_last  <= 1'b0;
         r_addr  <= '0;
         r_txd   <= '0;
      end else begin
         r_start <= w_sel;
         r_done  <= '0;
         if (w_sel) begin
            r_owner <= w_sel_owner;
            r_grant <= (w_sel_owner == REQ1) ? 2'b10 : 2'b01;
            r_rdwr  <= w_req_rdwr;
            r_last  <= w_req_last;
            r_addr  <= w_req_addr;
            r_txd   <= w_req_txd;
         end
         if (w_capture) begin
            if (r_owner == REQ1) begin
               r_rxd1 <= i_i2cc_rxd;
               r_done <= 2'b10;
            end else begin
               r_rxd0 <= i_i2cc_rxd;
               r_done <= 2'b01;
            end
         end
         if (w_release) begin
            r_grant <= '0;
            r_rr    <= ~r_owner;
         end
      end
   end

`ifdef I2CC_ARB_LOCK_TIMEOUT_EN
   logic r_lock_err;

   i2cc_lock_timer #(
      .TIMEOUT (TIMEOUT),
      .TWIDTH  (TWIDTH)
   ) u_lock_timer (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_clear  (w_hold_clear),
      .i_enable (w_hold_idle),
      .o_expire (w_expire)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_lock_err <= 1'b0;
      end else if (w_hold_idle && w_expire) begin
         r_lock_err <= 1'b1;
      end
   end

   assign o_lock_err = r_lock_err;
`else
   assign w_expire   = 1'b0;
   assign o_lock_err = 1'b0;
`endif

   assign o_i2cc_start = r_start;
   assign o_i2cc_rdwr  = r_rdwr;
   assign o_i2cc_last  = r_last;
   assign o_i2cc_addr  = r_addr;
   assign o_i2cc_txd   = r_txd;
   assign o_r0_rxd     = r_rxd0;
   assign o_r1_rxd     = r_rxd1;
   assign o_r0_done    = r_done[0];
   assign o_r1_done    = r_done[1];
   assign o_r0_grant   = r_grant[0];
   assign o_r1_grant   = r_grant[1];
   assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_i2cc_arbiter.sv
// Scoreboard bench for i2cc_arbiter: directed requester traffic, a simple
// controller model answering rxd = addr - 8'hA7, and an event monitor.
module tb_i2cc_arbiter;

   localparam int DW = 8;

   logic          clk = 1'b0;
   logic          i_rst = 1'b1;
   logic          i_r0_start = 1'b0, i_r0_rdwr = 1'b0, i_r0_last = 1'b0;
   logic [DW-1:0] i_r0_addr = '0, i_r0_txd = '0;
   logic          i_r1_start = 1'b0, i_r1_rdwr = 1'b0, i_r1_last = 1'b0;
   logic [DW-1:0] i_r1_addr = '0, i_r1_txd = '0;
   logic [DW-1:0] i_i2cc_rxd = '0;
   logic          i_i2cc_done = 1'b0;
   logic [DW-1:0] o_r0_rxd, o_r1_rxd, o_i2cc_addr, o_i2cc_txd;
   logic          o_r0_done, o_r0_grant, o_r1_done, o_r1_grant;
   logic          o_i2cc_start, o_i2cc_rdwr, o_i2cc_last, o_busy, o_lock_err;

   i2cc_arbiter #(.DWIDTH(DW), .TIMEOUT(100), .TWIDTH(8)) dut (
      .i_clk(clk), .i_rst(i_rst),
      .i_r0_start(i_r0_start), .i_r0_rdwr(i_r0_rdwr), .i_r0_last(i_r0_last),
      .i_r0_addr(i_r0_addr), .i_r0_txd(i_r0_txd), .o_r0_rxd(o_r0_rxd),
      .o_r0_done(o_r0_done), .o_r0_grant(o_r0_grant),
      .i_r1_start(i_r1_start), .i_r1_rdwr(i_r1_rdwr), .i_r1_last(i_r1_last),
      .i_r1_addr(i_r1_addr), .i_r1_txd(i_r1_txd), .o_r1_rxd(o_r1_rxd),
      .o_r1_done(o_r1_done), .o_r1_grant(o_r1_grant),
      .o_i2cc_start(o_i2cc_start), .o_i2cc_rdwr(o_i2cc_rdwr), .o_i2cc_last(o_i2cc_last),
      .o_i2cc_addr(o_i2cc_addr), .o_i2cc_txd(o_i2cc_txd),
      .i_i2cc_rxd(i_i2cc_rxd), .i_i2cc_done(i_i2cc_done),
      .o_busy(o_busy), .o_lock_err(o_lock_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit            is_done;
      bit            who;
      bit            rdwr;
      bit            last;
      logic [DW-1:0] addr;
      logic [DW-1:0] data;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_start(input bit who, input bit rdwr, input bit last,
                             input logic [DW-1:0] addr, input logic [DW-1:0] txd);
      exp_t e;
      e.is_done = 1'b0; e.who = who; e.rdwr = rdwr; e.last = last; e.addr = addr; e.data = txd;
      sb.push_back(e);
   endtask

   task automatic push_done(input bit who, input logic [DW-1:0] rxd);
      exp_t e;
      e.is_done = 1'b1; e.who = who; e.rdwr = 1'b0; e.last = 1'b0; e.addr = '0; e.data = rxd;
      sb.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Controller model: answers each command ctrl_delay cycles after its start pulse.
   int            ctrl_delay = 3;
   int            ctrl_cnt = 0;
   int            ctrl_done_cyc = -10;
   int            stray_req = 0;
   int            stray_ack = 0;
   logic [DW-1:0] ctrl_addr = '0;

   always @(negedge clk) begin
      i_i2cc_done = 1'b0;
      if (stray_req != stray_ack) begin
         i_i2cc_done = 1'b1;
         stray_ack++;
      end
      if (o_i2cc_start) begin
         ctrl_addr = o_i2cc_addr;
         ctrl_cnt  = ctrl_delay;
      end else if (ctrl_cnt > 0) begin
         ctrl_cnt--;
         if (ctrl_cnt == 0) begin
            i_i2cc_done   = 1'b1;
            i_i2cc_rxd    = ctrl_addr - 8'hA7;
            ctrl_done_cyc = cyc;
         end
      end
   end

   // Monitor: every start pulse or requester done pops one expected event.
   always @(negedge clk) begin
      exp_t e;
      if (o_i2cc_start || o_r0_done || o_r1_done) begin
         if (sb.size() == 0) begin
            check("unexpected_event", {29'd0, o_i2cc_start, o_r1_done, o_r0_done}, 32'd0);
         end else begin
            e = sb.pop_front();
            if (!e.is_done) begin
               check("start_fields",
                     {o_i2cc_start, o_r0_done | o_r1_done, o_r1_grant, o_r0_grant,
                      o_i2cc_rdwr, o_i2cc_last, o_i2cc_addr, o_i2cc_txd},
                     {1'b1, 1'b0, e.who, ~e.who, e.rdwr, e.last, e.addr, e.data});
            end else begin
               check("done_fields",
                     {o_i2cc_start, o_r1_done, o_r0_done, o_r1_grant, o_r0_grant,
                      (o_r1_done ? o_r1_rxd : o_r0_rxd)},
                     {1'b0, e.who, ~e.who, e.who, ~e.who, e.data});
               check("done_latency", cyc, ctrl_done_cyc + 1);
            end
         end
      end
   end

   task automatic do_byte(input bit who, input bit rdwr, input bit last,
                          input logic [DW-1:0] addr, input logic [DW-1:0] txd);
      bit seen = 1'b0;
      if (who) begin
         i_r1_rdwr = rdwr; i_r1_last = last; i_r1_addr = addr; i_r1_txd = txd; i_r1_start = 1'b1;
      end else begin
         i_r0_rdwr = rdwr; i_r0_last = last; i_r0_addr = addr; i_r0_txd = txd; i_r0_start = 1'b1;
      end
      for (int k = 0; k < 400 && !seen; k++) begin
         @(posedge clk);
         #1;
         seen = who ? o_r1_done : o_r0_done;
      end
      if (who) i_r1_start = 1'b0;
      else     i_r0_start = 1'b0;
      if (!seen) check(who ? "r1_done_timeout" : "r0_done_timeout", {31'd0, who ? o_r1_done : o_r0_done}, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit got;

      // Reset values
      tick(3);
      check("rst_i2cc", {o_i2cc_start, o_i2cc_rdwr, o_i2cc_last, o_i2cc_addr, o_i2cc_txd}, 32'd0);
      check("rst_req", {o_r0_rxd, o_r0_done, o_r0_grant, o_r1_rxd, o_r1_done, o_r1_grant}, 32'd0);
      check("rst_status", {o_busy, o_lock_err}, 32'd0);
      i_rst = 1'b0;
      tick(2);

      // Simultaneous requests out of reset: R0 first, then R1
      ctrl_delay = 3;
      push_start(1'b0, 1'b0, 1'b1, 8'h10, 8'h01); push_done(1'b0, 8'h69);
      push_start(1'b1, 1'b0, 1'b1, 8'h20, 8'h02); push_done(1'b1, 8'h79);
      fork
         do_byte(1'b0, 1'b0, 1'b1, 8'h10, 8'h01);
         do_byte(1'b1, 1'b0, 1'b1, 8'h20, 8'h02);
      join
      tick(2);
      check("idle_after_pair", {31'd0, o_busy}, 32'd0);

      // Single write from R0 with a slow controller; start one cycle after request
      ctrl_delay = 20;
      push_start(1'b0, 1'b0, 1'b1, 8'hF4, 8'h27); push_done(1'b0, 8'h4D);
      fork
         do_byte(1'b0, 1'b0, 1'b1, 8'hF4, 8'h27);
         begin
            tick(1);
            check("start_latency", {31'd0, o_i2cc_start}, 32'd1);
         end
      join
      tick(2);
      check("idle_after_write", {o_busy, o_r0_grant, o_r1_grant}, 32'd0);

      // Round-robin pointer now favours R1
      ctrl_delay = 3;
      push_start(1'b1, 1'b0, 1'b1, 8'h30, 8'h03); push_done(1'b1, 8'h89);
      push_start(1'b0, 1'b0, 1'b1, 8'h40, 8'h04); push_done(1'b0, 8'h99);
      fork
         do_byte(1'b0, 1'b0, 1'b1, 8'h40, 8'h04);
         do_byte(1'b1, 1'b0, 1'b1, 8'h30, 8'h03);
      join
      tick(2);

      // Eight-byte burst read by R0 while R1 keeps requesting
      for (int i = 0; i < 8; i++) begin
         push_start(1'b0, 1'b1, (i == 7), 8'hF7 + 8'(i), 8'h00);
         push_done(1'b0, 8'h50 + 8'(i));
      end
      push_start(1'b1, 1'b0, 1'b1, 8'hA0, 8'h11); push_done(1'b1, 8'hF9);
      fork
         begin
            for (int i = 0; i < 8; i++) do_byte(1'b0, 1'b1, (i == 7), 8'hF7 + 8'(i), 8'h00);
         end
         begin
            tick(1);
            do_byte(1'b1, 1'b0, 1'b1, 8'hA0, 8'h11);
         end
      join
      tick(2);

      // Stray controller done in IDLE and in ISSUE
      stray_req++;
      tick(3);
      check("stray_idle", {o_busy, o_r0_done, o_r1_done}, 32'd0);
      push_start(1'b1, 1'b0, 1'b1, 8'h55, 8'h66); push_done(1'b1, 8'hAE);
      fork
         do_byte(1'b1, 1'b0, 1'b1, 8'h55, 8'h66);
         begin
            tick(1);
            stray_req++;
         end
      join
      tick(2);

      // Reset while waiting for the controller
      ctrl_delay = 6;
      push_start(1'b0, 1'b0, 1'b1, 8'h77, 8'h88);
      i_r0_rdwr = 1'b0; i_r0_last = 1'b1; i_r0_addr = 8'h77; i_r0_txd = 8'h88; i_r0_start = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 20 && !got; k++) begin
         tick(1);
         got = o_i2cc_start;
      end
      if (!got) check("rst_wait_start_timeout", {31'd0, o_i2cc_start}, 32'd1);
      tick(2);
      i_rst = 1'b1;
      i_r0_start = 1'b0;
      tick(1);
      check("rstw_i2cc", {o_i2cc_start, o_i2cc_rdwr, o_i2cc_last, o_i2cc_addr, o_i2cc_txd}, 32'd0);
      check("rstw_req", {o_r0_rxd, o_r0_done, o_r0_grant, o_r1_rxd, o_r1_done, o_r1_grant}, 32'd0);
      check("rstw_status", {o_busy, o_lock_err}, 32'd0);
      i_rst = 1'b0;
      tick(10);
      check("aborted_done_ignored", {o_busy, o_r0_grant, o_r1_grant}, 32'd0);
      ctrl_delay = 3;
      push_start(1'b1, 1'b0, 1'b1, 8'h12, 8'h34); push_done(1'b1, 8'h6B);
      do_byte(1'b1, 1'b0, 1'b1, 8'h12, 8'h34);
      tick(2);

      // R1 opens a transaction with last=0 and goes silent while R0 waits
      push_start(1'b1, 1'b0, 1'b0, 8'h21, 8'h43); push_done(1'b1, 8'h7A);
      do_byte(1'b1, 1'b0, 1'b0, 8'h21, 8'h43);
`ifdef I2CC_ARB_LOCK_TIMEOUT_EN
      push_start(1'b0, 1'b0, 1'b1, 8'h65, 8'h87); push_done(1'b0, 8'hBE);
      fork
         do_byte(1'b0, 1'b0, 1'b1, 8'h65, 8'h87);
         begin
            n = 0;
            got = 1'b0;
            for (int k = 0; k < 300 && !got; k++) begin
               tick(1);
               n++;
               got = o_lock_err;
            end
            check("timeout_cycles", n, 32'd101);
            check("timeout_release", {o_lock_err, o_r1_grant}, 32'd2);
         end
      join
      tick(5);
      check("lock_err_sticky", {31'd0, o_lock_err}, 32'd1);
      i_rst = 1'b1;
      tick(1);
      check("lock_err_cleared", {31'd0, o_lock_err}, 32'd0);
      i_rst = 1'b0;
`else
      i_r0_rdwr = 1'b0; i_r0_last = 1'b1; i_r0_addr = 8'h65; i_r0_txd = 8'h87; i_r0_start = 1'b1;
      tick(150);
      check("hold_no_timeout", {o_busy, o_r1_grant, o_r0_grant, o_lock_err}, 32'hC);
      push_start(1'b1, 1'b0, 1'b1, 8'h22, 8'h44); push_done(1'b1, 8'h7B);
      push_start(1'b0, 1'b0, 1'b1, 8'h65, 8'h87); push_done(1'b0, 8'hBE);
      fork
         do_byte(1'b1, 1'b0, 1'b1, 8'h22, 8'h44);
         do_byte(1'b0, 1'b0, 1'b1, 8'h65, 8'h87);
      join
`endif
      tick(20);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
